// File: rtl/mem_reg_acc.sv
// Data bank with one read/write port and one forwarding read port, plus saturating accumulators.
// A clear sequencer zeroes the bank after reset or on command.
module mem_reg_acc #(
    parameter int W       = 24,
    parameter int NR      = 32,
    parameter int ADDRW   = 5,
    parameter int NACC    = 2,
    parameter int ACCW    = 1,
    parameter bit FORWARD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [ADDRW-1:0]     dira,
    input  logic [ADDRW-1:0]     dirb,
    input  logic [W-1:0]         data,
    output logic [W-1:0]         A,
    output logic [W-1:0]         B,
    input  logic                 clr_start,
    output logic                 busy,
    input  logic [1:0]           acc_op,
    input  logic [ACCW-1:0]      acc_sel,
    input  logic [W-1:0]         acc_d,
    output logic [NACC*W-1:0]    acc_q,
    output logic [NACC-1:0]      acc_ovf
);

    localparam logic [ADDRW:0] NR_L = (ADDRW+1)'(NR);
    localparam logic [ADDRW:0] LAST = (ADDRW+1)'(NR - 1);

    typedef enum logic {IDLE, CLEAR} state_t;
    typedef enum logic [1:0] {ACC_HOLD, ACC_LOAD, ACC_ADD, ACC_CLR} acc_op_t;

    state_t           state;
    logic [ADDRW-1:0] clr_addr;
    logic [W-1:0]     mem [NR];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if ({1'b0, clr_addr} == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic a_ok, b_ok, fwd;
    assign a_ok = ({1'b0, dira} < NR_L);
    assign b_ok = ({1'b0, dirb} < NR_L);
    assign fwd  = FORWARD && write && !busy && (dirb == dira);

    // Sweep owns the write port while busy; user writes are dropped, not queued.
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [W-1:0]     wdata;
    always_comb begin
        we    = 1'b0;
        waddr = dira;
        wdata = data;
        if (busy) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (write && a_ok) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign A = a_ok ? mem[dira] : '0;
    assign B = fwd ? data : (b_ok ? mem[dirb] : '0);

    for (genvar k = 0; k < NACC; k++) begin : g_acc
        logic [W-1:0] q;
        logic         f;
        logic [W:0]   sum;
        logic         hit;

        assign sum = {q[W-1], q} + {acc_d[W-1], acc_d};
        assign hit = (acc_sel == ACCW'(k));

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
                f <= 1'b0;
            end else if (hit) begin
                case (acc_op_t'(acc_op))
                    ACC_LOAD: q <= acc_d;
                    ACC_ADD: begin
                        // Sign bits disagree only when the W-bit result wrapped.
                        if (sum[W] != sum[W-1]) begin
                            q <= sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                            f <= 1'b1;
                        end else begin
                            q <= sum[W-1:0];
                        end
                    end
                    ACC_CLR: begin
                        q <= '0;
                        f <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        assign acc_q[k*W +: W] = q;
        assign acc_ovf[k]      = f;
    end

endmodule

// File: tb/tb_mem_reg_acc.sv
// Scoreboard bench for mem_reg_acc: stimulus queues expectations, a negedge monitor checks them.
module tb_mem_reg_acc;

    localparam int W = 24, NR = 32, ADDRW = 5, NACC = 2, ACCW = 1;

    logic              clk = 1'b0;
    logic              rst, write, clr_start;
    logic [ADDRW-1:0]  dira, dirb;
    logic [W-1:0]      data, acc_d;
    logic [1:0]        acc_op;
    logic [ACCW-1:0]   acc_sel;
    logic [W-1:0]      rd_a, rd_b, rd_a_nf, rd_b_nf;
    logic              busy, busy_nf;
    logic [NACC*W-1:0] acc_q, acc_q_nf;
    logic [NACC-1:0]   acc_ovf, acc_ovf_nf;

    always #5 clk = ~clk;

    mem_reg_acc #(.W(W), .NR(NR), .ADDRW(ADDRW), .NACC(NACC), .ACCW(ACCW), .FORWARD(1'b1)) dut (
        .clk(clk), .rst(rst), .write(write), .dira(dira), .dirb(dirb), .data(data),
        .A(rd_a), .B(rd_b), .clr_start(clr_start), .busy(busy), .acc_op(acc_op),
        .acc_sel(acc_sel), .acc_d(acc_d), .acc_q(acc_q), .acc_ovf(acc_ovf));

    mem_reg_acc #(.W(W), .NR(NR), .ADDRW(ADDRW), .NACC(NACC), .ACCW(ACCW), .FORWARD(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .write(write), .dira(dira), .dirb(dirb), .data(data),
        .A(rd_a_nf), .B(rd_b_nf), .clr_start(clr_start), .busy(busy_nf), .acc_op(acc_op),
        .acc_sel(acc_sel), .acc_d(acc_d), .acc_q(acc_q_nf), .acc_ovf(acc_ovf_nf));

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    localparam int S_A = 0, S_B = 1, S_BNF = 2, S_BUSY = 3, S_ACC = 4, S_OVF = 5;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    task automatic expect_v(input int sig, input logic [63:0] e, input string n);
        exp_t t;
        t.sig = sig; t.exp = e; t.name = n;
        sb.push_back(t);
    endtask

    task automatic check_now(input logic [63:0] act, input logic [63:0] e, input string n);
        chk_cnt++;
        if (act === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA5, b, 8'h5A};
    endfunction

    task automatic acc_do(input logic [1:0] op, input logic [ACCW-1:0] sel, input logic [W-1:0] d);
        acc_op = op; acc_sel = sel; acc_d = d;
        step();
        acc_op = 2'b00;
    endtask

    always @(negedge clk) begin
        exp_t        t;
        logic [63:0] act;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            case (t.sig)
                S_A:     act = {40'b0, rd_a};
                S_B:     act = {40'b0, rd_b};
                S_BNF:   act = {40'b0, rd_b_nf};
                S_BUSY:  act = {63'b0, busy};
                S_ACC:   act = {16'b0, acc_q};
                default: act = {62'b0, acc_ovf};
            endcase
            chk_cnt++;
            if (act === t.exp) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", t.name, act, t.exp);
        end
    end

    initial begin
        rst = 1'b1; write = 1'b0; clr_start = 1'b0; dira = '0; dirb = '0;
        data = '0; acc_d = '0; acc_op = 2'b00; acc_sel = '0;

        // 1: reset then 32-cycle sweep
        step(); step();
        rst = 1'b0;
        check_now({63'b0, busy}, 64'd1, "rst_state_busy");
        check_now({16'b0, acc_q}, 64'd0, "rst_state_acc_q");
        check_now({62'b0, acc_ovf}, 64'd0, "rst_state_acc_ovf");
        expect_v(S_BUSY, 1, "rst_busy[0]");
        expect_v(S_ACC, 0, "rst_acc_q");
        expect_v(S_OVF, 0, "rst_acc_ovf");
        for (int i = 1; i < 32; i++) begin
            step();
            expect_v(S_BUSY, 1, $sformatf("rst_busy[%0d]", i));
        end
        step();
        expect_v(S_BUSY, 0, "rst_busy_end");
        check_now({63'b0, busy}, 64'd0, "rst_wait_expired");
        for (int i = 0; i < NR; i++) begin
            dira = ADDRW'(i); dirb = ADDRW'(31 - i);
            expect_v(S_A, 0, $sformatf("clr0_A[%0d]", i));
            expect_v(S_B, 0, $sformatf("clr0_B[%0d]", i));
            step();
        end

        // 2: fill and read back on both ports
        write = 1'b1;
        for (int i = 0; i < NR; i++) begin
            dira = ADDRW'(i); dirb = ADDRW'(i); data = pat(i);
            step();
        end
        write = 1'b0;
        for (int i = 0; i < NR; i++) begin
            dira = ADDRW'(i); dirb = ADDRW'(31 - i);
            expect_v(S_A, {40'b0, pat(i)}, $sformatf("fill_A[%0d]", i));
            expect_v(S_B, {40'b0, pat(31 - i)}, $sformatf("fill_B[%0d]", i));
            step();
        end

        // 3: forwarding
        write = 1'b1; dira = 5'd3; dirb = 5'd3; data = 24'hDEADBE;
        expect_v(S_A, 64'hA5035A, "fwd_A_before");
        expect_v(S_B, 64'hDEADBE, "fwd_B_before");
        expect_v(S_BNF, 64'hA5035A, "nofwd_B_before");
        step();
        write = 1'b0;
        expect_v(S_A, 64'hDEADBE, "fwd_A_after");
        expect_v(S_BNF, 64'hDEADBE, "nofwd_B_after");

        // 4: accumulators
        acc_do(2'b01, 1'b0, 24'h000010);
        expect_v(S_ACC, 64'h000000_000010, "acc0_load");
        acc_do(2'b10, 1'b0, 24'h000005);
        expect_v(S_ACC, 64'h000000_000015, "acc0_add");
        expect_v(S_OVF, 0, "acc0_ovf");
        acc_do(2'b01, 1'b1, 24'h7FFFF0);
        expect_v(S_ACC, 64'h7FFFF0_000015, "acc1_load_pos");
        acc_do(2'b10, 1'b1, 24'h000020);
        expect_v(S_ACC, 64'h7FFFFF_000015, "acc1_sat_pos");
        expect_v(S_OVF, 2, "acc1_ovf_pos");
        acc_do(2'b01, 1'b1, 24'h800008);
        expect_v(S_ACC, 64'h800008_000015, "acc1_load_neg");
        expect_v(S_OVF, 2, "acc1_ovf_load_keep");
        acc_do(2'b10, 1'b1, 24'hFFFFF0);
        expect_v(S_ACC, 64'h800000_000015, "acc1_sat_neg");
        expect_v(S_OVF, 2, "acc1_ovf_neg");
        acc_do(2'b11, 1'b1, 24'h123456);
        expect_v(S_ACC, 64'h000000_000015, "acc1_clear");
        expect_v(S_OVF, 0, "acc1_ovf_clear");

        // 5: commanded sweep, writes dropped, accumulators still live
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            expect_v(S_BUSY, 1, $sformatf("sw_busy[%0d]", c));
            if (c == 2) begin
                dira = 5'd20;
                expect_v(S_A, {40'b0, pat(20)}, "sw_uncleared_A");
            end
            if (c == 4) begin
                acc_op = 2'b01; acc_sel = 1'b0; acc_d = 24'h000123;
            end
            if (c == 5) begin
                acc_op = 2'b00;
                expect_v(S_ACC, 64'h000000_000123, "sw_acc_load");
            end
            if (c == 10) begin
                write = 1'b1; dira = 5'd5; dirb = 5'd5; data = 24'h123456;
                expect_v(S_B, 0, "sw_no_fwd_B");
            end
            if (c == 11) begin
                write = 1'b0; dira = 5'd5;
                expect_v(S_A, 0, "sw_write_dropped");
            end
            step();
        end
        expect_v(S_BUSY, 0, "sw_busy_end");
        check_now({63'b0, busy}, 64'd0, "sw_wait_expired");
        for (int i = 0; i < NR; i++) begin
            dira = ADDRW'(i); dirb = ADDRW'(31 - i);
            expect_v(S_A, 0, $sformatf("clr1_A[%0d]", i));
            expect_v(S_B, 0, $sformatf("clr1_B[%0d]", i));
            step();
        end
        acc_do(2'b01, 1'b1, 24'h7FFFFF);
        acc_do(2'b10, 1'b1, 24'h000001);
        expect_v(S_OVF, 2, "pre_rst_ovf");

        // 6: reset mid-sweep restarts it
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1;
        expect_v(S_BUSY, 1, "rst_mid_busy");
        step();
        rst = 1'b0;
        expect_v(S_ACC, 0, "rst_mid_acc_q");
        expect_v(S_OVF, 0, "rst_mid_ovf");
        expect_v(S_BUSY, 1, "rst2_busy[0]");
        for (int i = 1; i < 32; i++) begin
            step();
            expect_v(S_BUSY, 1, $sformatf("rst2_busy[%0d]", i));
        end
        step();
        expect_v(S_BUSY, 0, "rst2_busy_end");
        check_now({63'b0, busy}, 64'd0, "rst2_wait_expired");

        @(negedge clk);
        #1;
        if (pass_cnt != chk_cnt) $display("FAIL summary: %0d of %0d checks failed", chk_cnt - pass_cnt, chk_cnt);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_reg_acc.md
Name: mem_reg_acc

Overview:
Parametrised successor to the Kalman-filter memory-register block. It holds an NR x W data bank with one write/read port A and one read-only port B, where port B can forward the write data. It also holds NACC general accumulators with load, saturating-add and clear operations. A hardware clear sequencer zeroes the data bank after reset or on command, so the KF datapath always starts from known state.

Parameters:
W, 24, data word width (two's complement)
NR, 32, number of data-bank registers
ADDRW, 5, address width; NR <= 2**ADDRW
NACC, 2, number of accumulators (acc 0 = RQ, acc 1 = RD in the 2-state KF)
ACCW, 1, accumulator select width; must be >= 1 and 2**ACCW >= NACC
FORWARD, 1, 1 = port B forwards write data on address match; 0 = port B returns stored value

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
write  in  1  data-bank write enable
dira  in  ADDRW  port A address (read and write)
dirb  in  ADDRW  port B address (read only)
data  in  W  write data
A  out  W  port A read data (combinational)
B  out  W  port B read data (combinational, optional forwarding)
clr_start  in  1  one-cycle pulse that starts a data-bank clear sweep
busy  out  1  clear sweep in progress
acc_op  in  2  00 hold, 01 load, 10 saturating add, 11 clear
acc_sel  in  ACCW  target accumulator
acc_d  in  W  accumulator operand
acc_q  out  NACC*W  accumulator values; acc k sits at bits [k*W +: W]
acc_ovf  out  NACC  sticky saturation flag, one per accumulator

Behaviour:
- Reset (rst high at an edge):
  - acc_q = 0, acc_ovf = 0.
  - FSM goes to CLEAR with clr_addr = 0; busy = 1 while rst is high.
  - Data-bank contents are not reset directly. They are zeroed by the sweep.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start = 1; clr_addr loads 0.
  - In CLEAR: each cycle writes 0 to mem[clr_addr], then increments clr_addr. After writing NR-1, goes to IDLE.
  - Sweep takes exactly NR cycles after rst deasserts or after clr_start is sampled. busy falls in the cycle after mem[NR-1] is written.
  - clr_start while busy is ignored.
  - rst during CLEAR restarts the sweep from address 0.
- Data-bank write:
  - mem[dira] <= data at the edge when write = 1 and busy = 0; one-cycle write latency.
  - write while busy is dropped, not queued.
  - dira >= NR: write ignored.
- Reads:
  - A = mem[dira]; never forwards.
  - B = data when FORWARD = 1, write = 1, busy = 0 and dirb == dira. Otherwise B = mem[dirb].
  - Address >= NR reads 0.
  - During CLEAR, reads return current contents: already-cleared words read 0.
- Accumulators:
  - Only acc_sel is affected; others hold.
  - acc_sel >= NACC: operation ignored.
  - Load: acc <= acc_d. Flag unchanged.
  - Add: signed W-bit sum, saturated. Positive overflow gives 2**(W-1)-1; negative overflow gives -2**(W-1); either sets acc_ovf[sel].
  - Clear: acc <= 0 and acc_ovf[sel] <= 0.
  - Result is visible on acc_q the cycle after the edge.
  - Accumulators operate independently of busy.
- No multi-driver paths: the sweep write and the user write are muxed, and the sweep has priority.

Test Plan:
1. Pulse rst for 2 cycles, then release -> busy = 1 for exactly 32 cycles, then 0; all A/B reads return 000000; acc_q = 0, acc_ovf = 00.
2. Write {A5,i,5A} to i = 0..31, then read with dira = i, dirb = 31-i -> A = A5_i_5A, B = A5_(31-i)_5A for all i.
3. write = 1, dira = dirb = 3, data = DEADBE -> same cycle A = A5035A, B = DEADBE. After the edge, A = DEADBE. With FORWARD = 0, B = A5035A before the edge.
4. acc0 load 000010, then add 000005 -> acc0 = 000015, ovf[0] = 0. Then:
   - acc1 load 7FFFF0, add 000020 -> acc1 = 7FFFFF, ovf[1] = 1.
   - acc1 load 800008, add FFFFF0 -> acc1 = 800000, ovf[1] stays 1.
   - acc1 clear -> 000000, ovf[1] = 0.
   - acc0 unchanged throughout.
5. After test 2, pulse clr_start, issue write of 123456 to address 5 during the sweep -> write dropped; after 32 cycles all words read 0.
6. Pulse clr_start, assert rst at sweep cycle 10 -> acc_q = 0 and the sweep restarts at address 0; busy = 1 for 32 cycles after rst release.
